ycbcr_share_arb: RTL and testbench
==================================

YCBCR_SHARE_ARB -- requirements
Module: ycbcr_share_arb

Interface
REQ-001 Parameter LAT, default 4: cycles from cv_de high with cv_r/g/b to cv_de_o high with matching cv_y/cb/cr on the shared converter; legal range 1..16.
REQ-002 Parameter USER_W, default 2: width of the per-pixel sideband (sof, eol) carried alongside each pixel.
REQ-003 Reset is synchronous and active-high; one clock.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 s0_valid / s1_valid  input  1  requester pixel valid.
REQ-007 s0_ready / s1_ready  output  1  requester pixel accepted this cycle.
REQ-008 s0_rgb / s1_rgb  input  24  pixel {r[23:16], g[15:8], b[7:0]}.
REQ-009 s0_user / s1_user  input  USER_W  pixel sideband.
REQ-010 cv_r, cv_g, cv_b  output  8 each  converter input pixel.
REQ-011 cv_de  output  1  converter input data enable.
REQ-012 cv_y, cv_cb, cv_cr  input  8 each  converter result.
REQ-013 cv_de_o  input  1  converter output data enable.
REQ-014 m0_valid / m1_valid  output  1  converted pixel for channel 0 / 1; no backpressure.
REQ-015 m0_ycbcr / m1_ycbcr  output  24  {y, cb, cr}.
REQ-016 m0_user / m1_user  output  USER_W  sideband returned with the pixel.
REQ-017 err_sync  output  1  sticky flag: converter enable does not match the tag pipeline.

Function
REQ-018 Acceptance SHALL occur on any cycle with sN_valid and sN_ready both high; at most one channel SHALL be accepted per cycle.
REQ-019 sN_ready SHALL be combinational from the valids and the arbiter state.
REQ-020 Only one valid: that channel SHALL be granted.
REQ-021 Both valid: the channel not granted last SHALL be granted (round-robin).
REQ-022 Neither valid: no grant; the last-grant pointer SHALL be held.
REQ-023 Last-grant pointer after reset SHALL be channel 1, so channel 0 wins the first contention.
REQ-024 Accepted pixel SHALL appear registered on cv_r/g/b with cv_de=1 at the next cycle; on cycles with no acceptance, cv_de SHALL be 0 and cv_r/g/b SHALL hold their previous values.
REQ-025 Tag pipeline: depth LAT, shifting every cycle; each entry holds {valid, channel id, user}. The entry is written at the cycle cv_de is driven.
REQ-026 When cv_de_o is high, the tail tag SHALL route {cv_y, cv_cb, cv_cr} and the user bits to the tagged channel's m outputs, registered.
REQ-027 Accept-to-mN_valid latency SHALL be exactly LAT+2 cycles.
REQ-028 The non-addressed mN_valid SHALL be 0; mN_ycbcr and mN_user SHALL hold when mN_valid is 0.
REQ-029 Pixel order within each channel SHALL be preserved.
REQ-030 Sustained throughput SHALL be 1 pixel/cycle aggregate.
REQ-031 err_sync SHALL be set on any cycle where cv_de_o differs from the tail tag's valid bit.
REQ-032 err_sync SHALL remain set until rst.
REQ-033 On mismatch with tag valid=0, no mN_valid SHALL be asserted.

Reset
REQ-034 With rst high at a clock edge: sN_ready=0, cv_de=0, cv_r/g/b=0, all tag entries cleared, m0/m1 outputs=0, err_sync=0, pointer=channel 1.
REQ-035 Pixels in flight at reset SHALL be discarded; no mN_valid SHALL appear for them after reset release.
REQ-036 While rst is high, both sN_ready outputs SHALL be 0.

Configuration
REQ-037 With macro YCBCR_SHARE_ARB_STATS_EN defined, outputs grant_cnt0 / grant_cnt1 (16 bits each) SHALL count accepted pixels per channel, wrap 0xFFFF->0, and reset to 0.
REQ-038 Without YCBCR_SHARE_ARB_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-039 Reset state: s0_valid=1 at release, rgb=0xFF0000, LAT=4, stub converter of latency 4 -> s0_ready=1 at first cycle, m0_valid=1 six cycles later, m1_valid never asserted.
REQ-040 Contention: both valid continuously for 8 cycles -> grants alternate 0,1,0,1...; each channel receives 4 results, in order, with matching user bits.
REQ-041 Single channel back-to-back: s1 only, 16 pixels -> s1_ready=1 every cycle; 16 consecutive m1_valid pulses; m0_valid stays 0.
REQ-042 Sync error: stub drops one cv_de_o pulse -> err_sync rises that cycle and stays 1 until rst.
REQ-043 Reset mid-stream: rst for 1 cycle with 3 pixels in flight -> no mN_valid from them afterward; the next grant goes to channel 0 under contention.
REQ-044 Stats build: YCBCR_SHARE_ARB_STATS_EN defined, 70000 channel-0 pixels -> grant_cnt0=70000 mod 65536=4464; grant_cnt1=0.

Source files
------------

// File: rtl/ycbcr_share_arb_if.sv
// Bundle of requester, converter and result signals for ycbcr_share_arb.
// The slave modport is the arbiter's view; master is the surrounding system.
interface ycbcr_share_arb_if #(
    parameter int USER_W = 2
);
    logic              s0_valid;
    logic              s1_valid;
    logic              s0_ready;
    logic              s1_ready;
    logic [23:0]       s0_rgb;
    logic [23:0]       s1_rgb;
    logic [USER_W-1:0] s0_user;
    logic [USER_W-1:0] s1_user;

    logic [7:0]        cv_r;
    logic [7:0]        cv_g;
    logic [7:0]        cv_b;
    logic              cv_de;
    logic [7:0]        cv_y;
    logic [7:0]        cv_cb;
    logic [7:0]        cv_cr;
    logic              cv_de_o;

    logic              m0_valid;
    logic              m1_valid;
    logic [23:0]       m0_ycbcr;
    logic [23:0]       m1_ycbcr;
    logic [USER_W-1:0] m0_user;
    logic [USER_W-1:0] m1_user;
    logic              err_sync;

    modport slave (
        input  s0_valid, s1_valid, s0_rgb, s1_rgb, s0_user, s1_user,
        input  cv_y, cv_cb, cv_cr, cv_de_o,
        output s0_ready, s1_ready,
        output cv_r, cv_g, cv_b, cv_de,
        output m0_valid, m1_valid, m0_ycbcr, m1_ycbcr, m0_user, m1_user, err_sync
    );

    modport master (
        output s0_valid, s1_valid, s0_rgb, s1_rgb, s0_user, s1_user,
        output cv_y, cv_cb, cv_cr, cv_de_o,
        input  s0_ready, s1_ready,
        input  cv_r, cv_g, cv_b, cv_de,
        input  m0_valid, m1_valid, m0_ycbcr, m1_ycbcr, m0_user, m1_user, err_sync
    );
endinterface

// File: rtl/ycbcr_share_arb.sv
// Round-robin share of one fixed-latency RGB->YCbCr converter between two pixel streams.
// Optional per-channel grant counters are built when YCBCR_SHARE_ARB_STATS_EN is defined.
module ycbcr_share_arb #(
    parameter int LAT    = 4,
    parameter int USER_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    ycbcr_share_arb_if.slave bus
`ifdef YCBCR_SHARE_ARB_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);
    localparam int TW = USER_W + 2;

    logic              gnt0_s;
    logic              gnt1_s;
    logic              last_q;
    logic              last_d;
    logic [23:0]       cv_rgb_q;
    logic              cv_de_q;
    logic              cv_ch_q;
    logic [USER_W-1:0] cv_user_q;
    logic [TW-1:0]     tag_q [LAT];
    logic [TW-1:0]     tag_d;
    logic              tail_v_s;
    logic              tail_ch_s;
    logic [USER_W-1:0] tail_user_s;
    logic              hit0_s;
    logic              hit1_s;
    logic              m0_valid_q;
    logic              m1_valid_q;
    logic [23:0]       m0_ycbcr_q;
    logic [23:0]       m1_ycbcr_q;
    logic [USER_W-1:0] m0_user_q;
    logic [USER_W-1:0] m1_user_q;
    logic              err_q;

    // last_q = 1 means channel 1 was granted last, so channel 0 wins the next tie
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        last_d = last_q;
        if (rst) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (bus.s0_valid && (!bus.s1_valid || last_q)) begin
            gnt0_s = 1'b1;
            last_d = 1'b0;
        end else if (bus.s1_valid) begin
            gnt1_s = 1'b1;
            last_d = 1'b1;
        end else begin
            last_d = last_q;
        end
    end

    always_comb begin
        tag_d       = {cv_de_q, cv_ch_q, cv_user_q};
        tail_v_s    = tag_q[LAT-1][TW-1];
        tail_ch_s   = tag_q[LAT-1][USER_W];
        tail_user_s = tag_q[LAT-1][USER_W-1:0];
        hit0_s      = bus.cv_de_o && tail_v_s && !tail_ch_s;
        hit1_s      = bus.cv_de_o && tail_v_s && tail_ch_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= 1'b1;
            cv_de_q   <= 1'b0;
            cv_rgb_q  <= 24'd0;
            cv_ch_q   <= 1'b0;
            cv_user_q <= {USER_W{1'b0}};
        end else begin
            last_q  <= last_d;
            cv_de_q <= gnt0_s | gnt1_s;
            if (gnt1_s) begin
                cv_rgb_q  <= bus.s1_rgb;
                cv_ch_q   <= 1'b1;
                cv_user_q <= bus.s1_user;
            end else if (gnt0_s) begin
                cv_rgb_q  <= bus.s0_rgb;
                cv_ch_q   <= 1'b0;
                cv_user_q <= bus.s0_user;
            end
        end
    end

    // Tag entry is captured one cycle after cv_de so its tail lines up with cv_de_o
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= {TW{1'b0}};
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int i = 1; i < LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m0_valid_q <= 1'b0;
            m1_valid_q <= 1'b0;
            m0_ycbcr_q <= 24'd0;
            m1_ycbcr_q <= 24'd0;
            m0_user_q  <= {USER_W{1'b0}};
            m1_user_q  <= {USER_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            m0_valid_q <= hit0_s;
            m1_valid_q <= hit1_s;
            if (hit0_s) begin
                m0_ycbcr_q <= {bus.cv_y, bus.cv_cb, bus.cv_cr};
                m0_user_q  <= tail_user_s;
            end
            if (hit1_s) begin
                m1_ycbcr_q <= {bus.cv_y, bus.cv_cb, bus.cv_cr};
                m1_user_q  <= tail_user_s;
            end
            err_q <= err_q | (bus.cv_de_o != tail_v_s);
        end
    end

`ifdef YCBCR_SHARE_ARB_STATS_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            if (gnt0_s) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (gnt1_s) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

    assign bus.s0_ready = gnt0_s;
    assign bus.s1_ready = gnt1_s;
    assign bus.cv_r     = cv_rgb_q[23:16];
    assign bus.cv_g     = cv_rgb_q[15:8];
    assign bus.cv_b     = cv_rgb_q[7:0];
    assign bus.cv_de    = cv_de_q;
    assign bus.m0_valid = m0_valid_q;
    assign bus.m1_valid = m1_valid_q;
    assign bus.m0_ycbcr = m0_ycbcr_q;
    assign bus.m1_ycbcr = m1_ycbcr_q;
    assign bus.m0_user  = m0_user_q;
    assign bus.m1_user  = m1_user_q;
    assign bus.err_sync = err_q;
endmodule

// File: tb/tb_ycbcr_share_arb.sv
// Directed bench for ycbcr_share_arb with a latency-LAT stub converter ({g,b,r} rotation).
module tb_ycbcr_share_arb;
    localparam int LAT    = 4;
    localparam int USER_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    ycbcr_share_arb_if #(.USER_W(USER_W)) bus ();

`ifdef YCBCR_SHARE_ARB_STATS_EN
    logic [15:0] gc0;
    logic [15:0] gc1;
`endif

    ycbcr_share_arb #(.LAT(LAT), .USER_W(USER_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef YCBCR_SHARE_ARB_STATS_EN
        ,
        .grant_cnt0 (gc0),
        .grant_cnt1 (gc1)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] conv(input logic [23:0] rgb);
        return {rgb[15:8], rgb[7:0], rgb[23:16]};
    endfunction

    // Stub converter: fixed latency LAT, can swallow exactly one output pulse on request
    logic [24:0] stub_q [LAT];
    logic        drop_req  = 1'b0;
    logic        drop_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) stub_q[i] <= 25'd0;
        end else begin
            if (bus.cv_de && drop_req && !drop_done) begin
                stub_q[0] <= 25'd0;
                drop_done <= 1'b1;
            end else begin
                stub_q[0] <= {bus.cv_de, conv({bus.cv_r, bus.cv_g, bus.cv_b})};
            end
            for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
        end
    end

    assign bus.cv_de_o = stub_q[LAT-1][24];
    assign bus.cv_y    = stub_q[LAT-1][23:16];
    assign bus.cv_cb   = stub_q[LAT-1][15:8];
    assign bus.cv_cr   = stub_q[LAT-1][7:0];

    // Observed results {cycle, pad, user, ycbcr} and expected ones
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [63:0] e0 [$];
    logic [63:0] e1 [$];

    always @(posedge clk) begin
        #2;
        if (bus.m0_valid === 1'b1) q0.push_back({cyc, 6'd0, bus.m0_user, bus.m0_ycbcr});
        if (bus.m1_valid === 1'b1) q1.push_back({cyc, 6'd0, bus.m1_user, bus.m1_ycbcr});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from a negedge; report readies and log expected results of accepts
    task automatic step(input logic v0, input logic [23:0] r0, input logic [1:0] u0,
                        input logic v1, input logic [23:0] r1, input logic [1:0] u1,
                        output logic rd0, output logic rd1);
        bus.s0_valid = v0;
        bus.s0_rgb   = r0;
        bus.s0_user  = u0;
        bus.s1_valid = v1;
        bus.s1_rgb   = r1;
        bus.s1_user  = u1;
        #1;
        rd0 = bus.s0_ready;
        rd1 = bus.s1_ready;
        if (v0 && rd0 === 1'b1) e0.push_back({cyc + LAT + 2, 6'd0, u0, conv(r0)});
        if (v1 && rd1 === 1'b1) e1.push_back({cyc + LAT + 2, 6'd0, u1, conv(r1)});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_cnt0"}, q0.size(), e0.size());
        chk({tag, "_cnt1"}, q1.size(), e1.size());
        while (q0.size() > 0 && e0.size() > 0) chk({tag, "_m0"}, q0.pop_front(), e0.pop_front());
        while (q1.size() > 0 && e1.size() > 0) chk({tag, "_m1"}, q1.pop_front(), e1.pop_front());
        q0.delete();
        q1.delete();
        e0.delete();
        e1.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rd0;
        logic rd1;
        int   k;
        int   i0;
        int   i1;

        bus.s0_valid = 1'b1;
        bus.s0_rgb   = 24'hFF0000;
        bus.s0_user  = 2'd1;
        bus.s1_valid = 1'b0;
        bus.s1_rgb   = 24'd0;
        bus.s1_user  = 2'd0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_s0_ready", bus.s0_ready, 1'b0);
        chk("rst_s1_ready", bus.s1_ready, 1'b0);
        chk("rst_cv_de", bus.cv_de, 1'b0);
        chk("rst_cv_r", bus.cv_r, 8'h00);
        chk("rst_m0_valid", bus.m0_valid, 1'b0);
        chk("rst_m1_valid", bus.m1_valid, 1'b0);
        chk("rst_err", bus.err_sync, 1'b0);

        // First pixel after release: s0 granted, result six cycles later
        rst = 1'b0;
        step(1'b1, 24'hFF0000, 2'd1, 1'b0, 24'd0, 2'd0, rd0, rd1);
        chk("p1_s0_ready", rd0, 1'b1);
        chk("p1_cv_de", bus.cv_de, 1'b1);
        chk("p1_cv_r", {bus.cv_r, bus.cv_g, bus.cv_b}, 24'hFF0000);
        idle(4);
        chk("p1_cv_de_idle", bus.cv_de, 1'b0);
        chk("p1_cv_hold", {bus.cv_r, bus.cv_g, bus.cv_b}, 24'hFF0000);
        chk("p1_m0_early", bus.m0_valid, 1'b0);
        idle(1);
        chk("p1_m0_valid", bus.m0_valid, 1'b1);
        chk("p1_m0_ycbcr", bus.m0_ycbcr, 24'h0000FF);
        chk("p1_m0_user", bus.m0_user, 2'd1);
        idle(1);
        chk("p1_m0_hold", bus.m0_ycbcr, 24'h0000FF);
        chk("p1_m0_drop", bus.m0_valid, 1'b0);
        drain("p1");

        // Contention: channel 0 was last, so grants go 1,0,1,0...
        i0 = 0;
        i1 = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 24'h102030 + 24'(i0), 2'(i0), 1'b1, 24'h8090A0 + 24'(i1), 2'(i1 + 1), rd0, rd1);
            chk("p2_rd0", rd0, (i % 2 == 1));
            chk("p2_rd1", rd1, (i % 2 == 0));
            if (rd0 === 1'b1) i0++;
            if (rd1 === 1'b1) i1++;
        end
        idle(LAT + 4);
        drain("p2");

        // Channel 1 alone, back-to-back
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 24'd0, 2'd0, 1'b1, 24'h400000 + 24'(i * 3), 2'(i), rd0, rd1);
            chk("p3_rd1", rd1, 1'b1);
        end
        idle(LAT + 4);
        drain("p3");
        chk("p3_err", bus.err_sync, 1'b0);

        // Converter drops one output pulse
        drop_req = 1'b1;
        k = cyc;
        step(1'b1, 24'h0A0B0C, 2'd2, 1'b0, 24'd0, 2'd0, rd0, rd1);
        chk("p4_rd0", rd0, 1'b1);
        e0.delete();
        idle(LAT);
        chk("p4_cyc", cyc, k + LAT + 1);
        chk("p4_err_before", bus.err_sync, 1'b0);
        idle(1);
        chk("p4_err_rise", bus.err_sync, 1'b1);
        chk("p4_no_m0", bus.m0_valid, 1'b0);
        step(1'b1, 24'h0D0E0F, 2'd3, 1'b0, 24'd0, 2'd0, rd0, rd1);
        chk("p4_rd0b", rd0, 1'b1);
        idle(LAT + 4);
        chk("p4_err_sticky", bus.err_sync, 1'b1);
        drain("p4");

        // Reset with three channel-1 pixels in flight
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 24'd0, 2'd0, 1'b1, 24'hC00000 + 24'(i), 2'(i), rd0, rd1);
            chk("p5_rd1", rd1, 1'b1);
        end
        rst = 1'b1;
        step(1'b1, 24'h111111, 2'd1, 1'b1, 24'h222222, 2'd2, rd0, rd1);
        chk("p5_rst_rd0", rd0, 1'b0);
        chk("p5_rst_rd1", rd1, 1'b0);
        e1.delete();
        rst = 1'b0;
        chk("p5_err_clr", bus.err_sync, 1'b0);
        step(1'b1, 24'h111111, 2'd1, 1'b1, 24'h222222, 2'd2, rd0, rd1);
        chk("p5_first_rd0", rd0, 1'b1);
        chk("p5_first_rd1", rd1, 1'b0);
        step(1'b1, 24'h333333, 2'd3, 1'b1, 24'h222222, 2'd2, rd0, rd1);
        chk("p5_second_rd1", rd1, 1'b1);
        idle(LAT + 6);
        chk("p5_err", bus.err_sync, 1'b0);
        drain("p5");

`ifdef YCBCR_SHARE_ARB_STATS_EN
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("st_rst_cnt0", gc0, 16'd0);
        bus.s0_valid = 1'b1;
        bus.s0_rgb   = 24'h010203;
        bus.s0_user  = 2'd0;
        repeat (70000) @(negedge clk);
        bus.s0_valid = 1'b0;
        @(negedge clk);
        chk("st_cnt0", gc0, 16'd4464);
        chk("st_cnt1", gc1, 16'd0);
        idle(LAT + 4);
        q0.delete();
        q1.delete();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
